// File: rtl/cmp_pkg.sv
// Relation encoding and one-hot flag decode for the comparator and crossing detector.
package cmp_pkg;

  localparam int unsigned REL_W = 2;

  typedef enum logic [REL_W-1:0] {
    REL_UNKNOWN = 2'b00,
    REL_BELOW   = 2'b01,
    REL_EQUAL   = 2'b10,
    REL_ABOVE   = 2'b11
  } rel_e;

  typedef struct packed {
    logic ok;
    rel_e rel;
  } decode_t;

  // ok is low unless exactly one of the three flags is set
  function automatic decode_t onehot_decode(input logic equal, input logic lower,
                                            input logic greater);
    decode_t d;
    d.ok  = 1'b1;
    d.rel = REL_UNKNOWN;
    case ({lower, equal, greater})
      3'b100:  d.rel = REL_BELOW;
      3'b010:  d.rel = REL_EQUAL;
      3'b001:  d.rel = REL_ABOVE;
      default: d.ok  = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/cmp_event_slot.sv
// Single-entry valid/ready event register.
// Ports: clk, rst_n (async low), load/payload_in (producer), ready (consumer accept),
//        valid/payload (slot contents), drop (load refused because slot full, no accept).
module cmp_event_slot #(
  parameter int unsigned PAYLOAD_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [PAYLOAD_W-1:0] payload_in,
  input  logic                 ready,
  output logic                 valid,
  output logic [PAYLOAD_W-1:0] payload,
  output logic                 drop
);

  logic space;

  // An accept in the same cycle frees the entry for the incoming load
  assign space = ~valid | ready;
  assign drop  = load & ~space;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid   <= 1'b0;
      payload <= '0;
    end else if (load && space) begin
      valid   <= 1'b1;
      payload <= payload_in;
    end else if (valid && ready) begin
      valid   <= 1'b0;
    end
  end

endmodule

// File: rtl/cmp_crossing_detector.sv
// Debounced relation tracker downstream of the magnitude comparator.
// Emits one event per committed relation change through a single-entry slot,
// counts crossings (saturating) and keeps sticky overrun / one-hot error flags.
// Ports: clk, rst_n (async low), clr (sync clear of count/sticky flags),
//        in_valid/equal/lower/greater (sample), state (committed relation),
//        event_valid/event_ready/event_from/event_to[/event_time] (event slot),
//        crossing_count, overrun, onehot_err.
// Option: define CMP_CROSS_TIMESTAMP_EN to add a 32-bit timestamp to each event.
module cmp_crossing_detector
  import cmp_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  input  logic             equal,
  input  logic             lower,
  input  logic             greater,
  output logic [REL_W-1:0] state,
  output logic             event_valid,
  input  logic             event_ready,
  output logic [REL_W-1:0] event_from,
  output logic [REL_W-1:0] event_to,
`ifdef CMP_CROSS_TIMESTAMP_EN
  output logic [31:0]      event_time,
`endif
  output logic [CNT_W-1:0] crossing_count,
  output logic             overrun,
  output logic             onehot_err
);

  localparam logic [7:0] DEB = 8'(DEBOUNCE_CYCLES);

`ifdef CMP_CROSS_TIMESTAMP_EN
  localparam int unsigned PW = 2 * REL_W + 32;
`else
  localparam int unsigned PW = 2 * REL_W;
`endif

  rel_e       state_q;
  rel_e       cand_q;
  rel_e       cand_d;
  logic [7:0] run_q;
  logic [7:0] run_d;
  logic       commit;
  logic       drop;
  decode_t    dec;
  logic [PW-1:0] slot_in;
  logic [PW-1:0] slot_out;

  always_comb begin
    dec    = onehot_decode(equal, lower, greater);
    cand_d = cand_q;
    run_d  = run_q;
    commit = 1'b0;
    if (in_valid) begin
      if (!dec.ok) begin
        run_d = '0;
      end else if (dec.rel == state_q) begin
        run_d  = '0;
        cand_d = state_q;
      end else if (dec.rel == cand_q) begin
        run_d = run_q + 8'd1;
      end else begin
        cand_d = dec.rel;
        run_d  = 8'd1;
      end
      // Commit on the edge that consumes the Nth sample, so state shows it next cycle
      commit = dec.ok && (dec.rel != state_q) && (run_d == DEB);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= REL_UNKNOWN;
      cand_q  <= REL_UNKNOWN;
      run_q   <= '0;
    end else begin
      cand_q <= cand_d;
      if (commit) begin
        state_q <= cand_d;
        run_q   <= '0;
      end else begin
        run_q <= run_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crossing_count <= '0;
      overrun        <= 1'b0;
      onehot_err     <= 1'b0;
    end else if (clr) begin
      crossing_count <= '0;
      overrun        <= 1'b0;
      onehot_err     <= 1'b0;
    end else begin
      if (commit && (state_q != REL_UNKNOWN) && (crossing_count != '1))
        crossing_count <= crossing_count + 1'b1;
      if (drop)
        overrun <= 1'b1;
      if (in_valid && !dec.ok)
        onehot_err <= 1'b1;
    end
  end

`ifdef CMP_CROSS_TIMESTAMP_EN
  logic [31:0] ts_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ts_q <= '0;
    else        ts_q <= ts_q + 32'd1;
  end

  assign slot_in    = {state_q, cand_d, ts_q};
  assign event_time = slot_out[31:0];
`else
  assign slot_in = {state_q, cand_d};
`endif

  cmp_event_slot #(.PAYLOAD_W(PW)) u_slot (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (commit),
    .payload_in (slot_in),
    .ready      (event_ready),
    .valid      (event_valid),
    .payload    (slot_out),
    .drop       (drop)
  );

  assign state      = state_q;
  assign event_from = slot_out[PW-1 -: REL_W];
  assign event_to   = slot_out[PW-REL_W-1 -: REL_W];

endmodule
